input_queue_register: RTL and testbench
=======================================

Name: input_queue_register

Overview:
- Serial-to-sparse-index converter at the neural-network input layer.
- After reset, captures one binary pixel per clock for INPUT_LAYER_NODES cycles.
- Then presents, in ascending order, the index of every pixel that was 1, one index per dequeue.
- Downstream accumulation logic uses these indices to fetch weights only for active inputs.

Parameters:
- INPUT_LAYER_NODES, default 784: number of pixels per image / input nodes; the bench uses 10.
- INDEX_WIDTH, default 10: width of indexOut. Must satisfy 2^INDEX_WIDTH >= INPUT_LAYER_NODES.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; starts a new image.
- pixelValue  input  1  current serial pixel during load phase (1 = active).
- dequeue  input  1  pop request, sampled on the rising edge; valid only in drain phase.
- indexOut  output  INDEX_WIDTH  index of the current queue head (lowest remaining active pixel).
- queueEmpty  output  1  high when finished and no active indices remain.
- finished  output  1  high once all INPUT_LAYER_NODES pixels have been captured.

Behaviour:
- Storage: INPUT_LAYER_NODES-bit active-pixel vector plus a load counter.
  - Counter width: INDEX_WIDTH+1, so it reaches INPUT_LAYER_NODES without wrapping.
- Reset asserted (low), asynchronously:
  - vector = 0, counter = 0.
  - finished = 0, queueEmpty = 0, indexOut = 0.
- Load phase (counter < INPUT_LAYER_NODES):
  - Each rising edge writes pixelValue into vector[counter] and increments counter.
  - The first edge after reset release captures index 0.
  - dequeue is ignored.
  - queueEmpty = 0 and indexOut = 0.
- When counter reaches INPUT_LAYER_NODES:
  - finished goes high, starting on the edge that captured the last pixel (registered).
  - finished stays high until the next reset.
  - Further pixelValue is ignored; the counter saturates.
- Drain phase (finished = 1):
  - indexOut = position of the lowest set bit of the vector, via a combinational priority encoder on the registered vector.
  - queueEmpty = 1 when the vector is all zero; indexOut = 0 while empty.
  - On a rising edge with dequeue = 1 and queueEmpty = 0, clear the head bit; the next index appears the same cycle the edge completes.
  - At most one pop per edge. Holding dequeue high pops on every edge.
  - A pop while empty is a no-op.
- Reset mid-load or mid-drain discards all contents; loading restarts at index 0.
- Zero-pixel image: queueEmpty rises together with finished.
- All-ones image: yields indices 0..INPUT_LAYER_NODES-1 in order.

Optional Feature:
- Macro: INPUT_QUEUE_COUNT_EN.
- When defined, adds output port activeCount, width INDEX_WIDTH+1:
  - During load: running count of active pixels captured.
  - Each successful pop decrements it.
  - Cleared by reset.
  - activeCount == 0 coincides with queueEmpty during drain.
- When undefined, the port and its counter do not exist; all other behaviour is unchanged.

Test Plan:
- Reset, then load 0,0,1,0,1,1,0,1,0,1 (N=10) -> finished high after the 10th edge. Pops return 2,4,5,7,9, then queueEmpty=1 with indexOut=0.
- Reset, then load 1,1,0,1,1,0,1,1,0,0 -> pops return 0,1,3,4,6,7, then empty. Extra dequeues leave queueEmpty=1 and state unchanged.
- Load all zeros -> finished=1 and queueEmpty=1 on the same cycle. Dequeue has no effect.
- Assert dequeue during load phase -> ignored. After finished, the first indexOut is still the lowest active index.
- Assert reset (low) mid-drain after two pops, then load 1,0,...,0,1 -> finished and queueEmpty clear immediately. New pops return 0,9 then empty.
- With INPUT_QUEUE_COUNT_EN, load 0,0,1,0,1,1,0,1,0,1 -> activeCount=5 at finished. It decrements 4,3,2,1,0 across pops.

Source files
------------

// File: rtl/input_queue_register_if.sv
// Pixel load / sparse index drain bus for input_queue_register.
// master: drives pixelValue, dequeue; slave: returns indexOut, queueEmpty, finished (+activeCount).
interface input_queue_register_if #(
    parameter int INDEX_WIDTH = 10
);
    logic                   pixelValue;
    logic                   dequeue;
    logic [INDEX_WIDTH-1:0] indexOut;
    logic                   queueEmpty;
    logic                   finished;
`ifdef INPUT_QUEUE_COUNT_EN
    logic [INDEX_WIDTH:0]   activeCount;

    modport master (
        output pixelValue, dequeue,
        input  indexOut, queueEmpty, finished, activeCount
    );
    modport slave (
        input  pixelValue, dequeue,
        output indexOut, queueEmpty, finished, activeCount
    );
`else
    modport master (
        output pixelValue, dequeue,
        input  indexOut, queueEmpty, finished
    );
    modport slave (
        input  pixelValue, dequeue,
        output indexOut, queueEmpty, finished
    );
`endif
endinterface

// File: rtl/input_queue_register.sv
// Serial pixel capture, then ascending drain of active pixel indices.
// Ports: clk, reset (async, active-low), q (slave: pixelValue, dequeue,
// indexOut, queueEmpty, finished). Optional macro INPUT_QUEUE_COUNT_EN
// adds q.activeCount, the number of active indices still queued.
module input_queue_register #(
    parameter int INPUT_LAYER_NODES = 784,
    parameter int INDEX_WIDTH       = 10
) (
    input logic clk,
    input logic reset,
    input_queue_register_if.slave q
);
    localparam int N  = INPUT_LAYER_NODES;
    localparam int CW = INDEX_WIDTH + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [N-1:0]  ONE  = N'(1);

    logic [N-1:0]           vec;
    logic [N-1:0]           vec_nxt;
    logic [CW-1:0]          cnt;
    logic                   fin;
    logic                   any;
    logic                   pop;
    logic [INDEX_WIDTH-1:0] head;

    assign any = |vec;
    assign pop = fin & q.dequeue & any;

    // Lowest set bit wins: scan downward so the last hit is the lowest.
    always_comb begin
        head = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) head = INDEX_WIDTH'(i);
        end
    end

    // x & (x - 1) clears exactly the lowest set bit, i.e. the head.
    always_comb begin
        vec_nxt = vec;
        if (!fin) begin
            for (int i = 0; i < N; i++) begin
                if (cnt == CW'(i)) vec_nxt[i] = q.pixelValue;
            end
        end else if (pop) begin
            vec_nxt = vec & (vec - ONE);
        end
    end

    // fin is set on the edge that captures the last pixel; the counter
    // then stops at N because it only advances while fin is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vec <= '0;
            cnt <= '0;
            fin <= 1'b0;
        end else begin
            vec <= vec_nxt;
            if (!fin) begin
                cnt <= cnt + CW'(1);
                fin <= (cnt == LAST);
            end
        end
    end

    assign q.finished   = fin;
    assign q.queueEmpty = fin & ~any;
    assign q.indexOut   = fin ? head : '0;

`ifdef INPUT_QUEUE_COUNT_EN
    logic [CW-1:0] acnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acnt <= '0;
        end else if (!fin) begin
            if (q.pixelValue) acnt <= acnt + CW'(1);
        end else if (pop) begin
            acnt <= acnt - CW'(1);
        end
    end

    assign q.activeCount = acnt;
`endif

endmodule

// File: tb/tb_input_queue_register.sv
// Self-checking bench for input_queue_register (N=10, INDEX_WIDTH=4).
// Directed table vectors plus randomized runs against a queue model.
module tb_input_queue_register;
    localparam int N  = 10;
    localparam int IW = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    input_queue_register_if #(.INDEX_WIDTH(IW)) bus();

    input_queue_register #(
        .INPUT_LAYER_NODES(N),
        .INDEX_WIDTH(IW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .q(bus)
    );

    typedef struct {
        logic [N-1:0] pix;
        int           deq_mode;
        int           n;
        int           exp[N];
    } vec_t;

    vec_t tbl[5];
    int   mq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_idx"}, 32'(bus.indexOut),
            (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
        chk({tag, "_empty"}, 32'(bus.queueEmpty), 32'(mq.size() == 0));
        chk({tag, "_fin"}, 32'(bus.finished), 32'd1);
`ifdef INPUT_QUEUE_COUNT_EN
        chk({tag, "_cnt"}, 32'(bus.activeCount), 32'(mq.size()));
`endif
    endtask

    // Async reset: outputs must clear before any clock edge.
    task automatic start_reset();
        @(negedge clk);
        reset = 1'b0;
        bus.pixelValue = 1'b0;
        bus.dequeue = 1'b0;
        #1;
        chk("rst_fin", 32'(bus.finished), 32'd0);
        chk("rst_empty", 32'(bus.queueEmpty), 32'd0);
        chk("rst_idx", 32'(bus.indexOut), 32'd0);
`ifdef INPUT_QUEUE_COUNT_EN
        chk("rst_cnt", 32'(bus.activeCount), 32'd0);
`endif
        mq.delete();
        @(negedge clk);
        reset = 1'b1;
    endtask

    // deq_mode: 0 low, 1 held high, 2 random. Stops early when k < N.
    task automatic load_img(input logic [N-1:0] pix, input int deq_mode,
                            input int k);
        int act = 0;
        mq.delete();
        for (int i = 0; i < k; i++) begin
            chk("load_fin", 32'(bus.finished), 32'd0);
            chk("load_empty", 32'(bus.queueEmpty), 32'd0);
            chk("load_idx", 32'(bus.indexOut), 32'd0);
`ifdef INPUT_QUEUE_COUNT_EN
            chk("load_cnt", 32'(bus.activeCount), 32'(act));
`endif
            bus.pixelValue = pix[i];
            bus.dequeue = (deq_mode == 1) ? 1'b1 :
                          (deq_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk);
            @(negedge clk);
            if (pix[i]) begin
                mq.push_back(i);
                act++;
            end
        end
        bus.dequeue = 1'b0;
        bus.pixelValue = 1'($urandom_range(0, 1));
        if (k == N) chk_state("loaded");
    endtask

    task automatic drain(input int cyc, input bit rnd);
        for (int c = 0; c < cyc; c++) begin
            logic d;
            chk_state("drain");
            d = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.dequeue = d;
            bus.pixelValue = 1'($urandom_range(0, 1));
            @(posedge clk);
            @(negedge clk);
            if (d && mq.size() != 0) void'(mq.pop_front());
        end
        bus.dequeue = 1'b0;
        chk_state("drain_end");
    endtask

    // Table vectors: drain expectations come from the table, not the model.
    task automatic run_table_entry(input int t);
        start_reset();
        load_img(tbl[t].pix, tbl[t].deq_mode, N);
        mq.delete();
        for (int j = 0; j < tbl[t].n; j++) mq.push_back(tbl[t].exp[j]);
        drain(tbl[t].n + 3, 1'b0);
    endtask

    initial begin
        bus.pixelValue = 1'b0;
        bus.dequeue = 1'b0;

        tbl[0] = '{pix: 10'b1010110100, deq_mode: 0, n: 5,
                   exp: '{2, 4, 5, 7, 9, 0, 0, 0, 0, 0}};
        tbl[1] = '{pix: 10'b0011011011, deq_mode: 0, n: 6,
                   exp: '{0, 1, 3, 4, 6, 7, 0, 0, 0, 0}};
        tbl[2] = '{pix: 10'b0000000000, deq_mode: 1, n: 0,
                   exp: '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
        tbl[3] = '{pix: 10'b1010110100, deq_mode: 1, n: 5,
                   exp: '{2, 4, 5, 7, 9, 0, 0, 0, 0, 0}};
        tbl[4] = '{pix: 10'b1111111111, deq_mode: 2, n: 10,
                   exp: '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9}};

        for (int t = 0; t < 5; t++) run_table_entry(t);

        // Reset mid-drain after two pops, then a new image 1,0,...,0,1.
        start_reset();
        load_img(10'b1010110100, 0, N);
        drain(2, 1'b0);
        start_reset();
        load_img(10'b1000000001, 0, N);
        chk("redo_head", 32'(bus.indexOut), 32'd0);
        drain(4, 1'b0);

        // Reset mid-load discards partial contents.
        start_reset();
        load_img(10'b1111111111, 0, 4);
        start_reset();
        load_img(10'b0000100000, 0, N);
        drain(3, 1'b0);

        // Randomized images, dequeue patterns and drain lengths.
        for (int r = 0; r < 30; r++) begin
            logic [N-1:0] pix;
            pix = N'($urandom);
            start_reset();
            if ($urandom_range(0, 5) == 0) begin
                load_img(pix, 2, int'($urandom_range(1, N - 1)));
            end else begin
                load_img(pix, 2, N);
                drain(int'($urandom_range(1, 2 * N + 4)), 1'b1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
